// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared defaults, buffer entry type and saturating increment
// for the FIFO read-side stream adapter.
package fifo_stream_pkg;
    localparam int DEF_DWIDTH  = 12;
    localparam int DEF_PKT_LEN = 16;

    typedef struct packed {
        logic [DEF_DWIDTH-1:0] data;
        logic                  last;
    } buf_entry_t;

    // Widened to 64 bits so one helper serves any counter width up to 64.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/fifo_rd_skid2.sv
// fifo_rd_skid2: 2-entry in-order buffer; head is a flop so the stream output
// is registered, tail only fills when a push arrives without a matching pop.
module fifo_rd_skid2
    import fifo_stream_pkg::*;
#(
    parameter type T = buf_entry_t
) (
    input  logic       clock,
    input  logic       sclr,
    input  logic       push,
    input  logic       pop,
    input  T           din,
    output T           head,
    output logic [1:0] occ
);
    T tail;

    always_ff @(posedge clock) begin
        if (sclr) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            occ <= occ + 2'(push) - 2'(pop);
            // push is never asserted at occ=2, so tail is only read on a pop from full
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
                head <= din;
            else if (pop && occ == 2'd2)
                head <= tail;
            if (push && occ == 2'd1 && !pop)
                tail <= din;
        end
    end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns a show-ahead FIFO read port into a registered
// valid/ready stream with fixed-length packet framing and saturating statistics.
module fifo_rd_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int CNT_W   = 32
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              en,
    input  logic [DWIDTH-1:0] fifo_q,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  pkt_cnt
);
    localparam int              IW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
    } entry_t;

    logic [1:0]    occ;
    logic [IW-1:0] wr_idx;
    logic          pop;
    entry_t        din;
    entry_t        head;

    // Request depends only on registered occupancy: no m_ready -> fifo_rdreq path.
    assign fifo_rdreq = en & ~fifo_rdempty & (occ != 2'd2) & ~sclr;
    assign m_valid    = (occ != 2'd0);
    assign pop        = m_valid & m_ready;
    assign din        = '{data: fifo_q, last: (wr_idx == LAST_IDX)};
    assign m_data     = head.data;
    assign m_last     = head.last;

    fifo_rd_skid2 #(.T(entry_t)) u_buf (
        .clock (clock),
        .sclr  (sclr),
        .push  (fifo_rdreq),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .occ   (occ)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_idx   <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (fifo_rdreq)
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
            if (pop)
                beat_cnt <= CNT_W'(sat_inc(64'(beat_cnt), 64'(CNT_MAX)));
            if (pop && m_last)
                pkt_cnt <= CNT_W'(sat_inc(64'(pkt_cnt), 64'(CNT_MAX)));
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: queue-based FIFO and sink model around the adapter,
// table-driven scenarios, hand-written corner cases and randomized traffic.
module tb_fifo_rd_stream_adapter;
    localparam int P = 16;

    logic        clock = 1'b0;
    logic        sclr, en, fifo_rdempty, fifo_rdreq, m_valid, m_ready, m_last;
    logic [11:0] fifo_q, m_data;
    logic [31:0] beat_cnt, pkt_cnt;

    logic        s_sclr, s_rdreq, s_valid, s_last;
    logic [11:0] s_data;
    logic [3:0]  s_beat, s_pkt;

    always #5 clock = ~clock;

    fifo_rd_stream_adapter #(.DWIDTH(12), .PKT_LEN(P), .CNT_W(32)) dut (
        .clock(clock), .sclr(sclr), .en(en), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq(fifo_rdreq), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
    );

    fifo_rd_stream_adapter #(.DWIDTH(12), .PKT_LEN(1), .CNT_W(4)) dut_sat (
        .clock(clock), .sclr(s_sclr), .en(1'b1), .fifo_q(12'h123), .fifo_rdempty(1'b0),
        .fifo_rdreq(s_rdreq), .m_data(s_data), .m_valid(s_valid), .m_ready(1'b1),
        .m_last(s_last), .beat_cnt(s_beat), .pkt_cnt(s_pkt)
    );

    typedef struct {
        int n;
        int mode;
        int cycles;
        int exp_beats;
        int exp_pkts;
        int exp_left;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] fifo[$];
    logic [11:0] expq[$];
    int          beats, pkts, rd_count;
    logic [11:0] last_word;
    bit          armed = 0;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, advance at posedge.
    task automatic cycle(input logic e, input logic r, input logic s);
        logic exp_rd, exp_v, do_pop, rd;
        @(negedge clock);
        en = e;
        m_ready = r;
        sclr = s;
        fifo_rdempty = (fifo.size() == 0);
        fifo_q = (fifo.size() > 0) ? fifo[0] : 12'h0;
        #1;
        exp_v  = (expq.size() > 0);
        exp_rd = e && (fifo.size() > 0) && (expq.size() < 2) && !s;
        rd     = fifo_rdreq;
        if (armed) begin
            chk("rdreq", 64'(fifo_rdreq), 64'(exp_rd));
            chk("m_valid", 64'(m_valid), 64'(exp_v));
            if (exp_v) begin
                chk("m_data", 64'(m_data), 64'(expq[0]));
                chk("m_last", 64'(m_last), 64'((beats % P) == P - 1));
            end
            chk("beat_cnt", 64'(beat_cnt), 64'(beats));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(pkts));
        end
        do_pop = exp_v && r;
        @(posedge clock);
        if (s) begin
            expq.delete();
            beats = 0;
            pkts = 0;
        end else begin
            if (do_pop) begin
                last_word = expq.pop_front();
                if (beats % P == P - 1) pkts++;
                beats++;
            end
            if (rd === 1'b1) begin
                rd_count++;
                if (fifo.size() > 0) expq.push_back(fifo.pop_front());
            end
        end
        #1;
    endtask

    task automatic preload(input int n);
        fifo.delete();
        for (int i = 1; i <= n; i++) fifo.push_back(12'(i));
    endtask

    initial begin
        vecs[0] = '{n: 40, mode: 0, cycles: 60, exp_beats: 40, exp_pkts: 2, exp_left: 0};
        vecs[1] = '{n: 10, mode: 1, cycles: 60, exp_beats: 10, exp_pkts: 0, exp_left: 0};
        vecs[2] = '{n: 10, mode: 2, cycles: 20, exp_beats: 0,  exp_pkts: 0, exp_left: 8};
        vecs[3] = '{n: 0,  mode: 0, cycles: 20, exp_beats: 0,  exp_pkts: 0, exp_left: 0};
        vecs[4] = '{n: 33, mode: 0, cycles: 50, exp_beats: 33, exp_pkts: 2, exp_left: 0};
        vecs[5] = '{n: 17, mode: 1, cycles: 80, exp_beats: 17, exp_pkts: 1, exp_left: 0};

        en = 0; m_ready = 0; sclr = 1; fifo_q = 0; fifo_rdempty = 1; s_sclr = 1;
        beats = 0; pkts = 0; rd_count = 0; last_word = 0;
        cycle(0, 0, 1);
        armed = 1;

        // reset state, with a loaded FIFO: no request while sclr is high
        preload(40);
        cycle(1, 1, 1);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_beat", 64'(beat_cnt), 64'd0);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);

        // first-word latency then continuous flow
        cycle(1, 1, 0);
        chk("lat_valid", 64'(m_valid), 64'd1);
        chk("lat_data", 64'(m_data), 64'd1);
        repeat (50) cycle(1, 1, 0);
        chk("flow_beats", 64'(beat_cnt), 64'd40);
        chk("flow_pkts", 64'(pkt_cnt), 64'd2);

        foreach (vecs[k]) begin
            preload(vecs[k].n);
            cycle(0, 0, 1);
            for (int c = 0; c < vecs[k].cycles; c++)
                cycle(1, (vecs[k].mode == 0) ? 1'b1 : (vecs[k].mode == 1) ? 1'((c % 3) == 0) : 1'b0, 0);
            chk("vec_beats", 64'(beat_cnt), 64'(vecs[k].exp_beats));
            chk("vec_pkts", 64'(pkt_cnt), 64'(vecs[k].exp_pkts));
            chk("vec_left", 64'(fifo.size()), 64'(vecs[k].exp_left));
        end

        // en gating after the 8th read
        preload(30);
        cycle(0, 0, 1);
        rd_count = 0;
        for (int i = 0; i < 50 && rd_count < 8; i++) cycle(1, 1, 0);
        chk("en_reads", 64'(rd_count), 64'd8);
        repeat (10) cycle(0, 1, 0);
        chk("en_beats", 64'(beat_cnt), 64'd8);
        chk("en_left", 64'(fifo.size()), 64'd22);
        cycle(1, 1, 0);
        chk("en_resume_valid", 64'(m_valid), 64'd1);
        chk("en_resume_data", 64'(m_data), 64'd9);

        // mid-packet sclr
        preload(40);
        cycle(0, 0, 1);
        for (int i = 0; i < 30 && beats < 5; i++) cycle(1, 1, 0);
        chk("mid_beats", 64'(beat_cnt), 64'd5);
        cycle(1, 1, 1);
        chk("mid_valid", 64'(m_valid), 64'd0);
        chk("mid_data", 64'(m_data), 64'd0);
        chk("mid_last", 64'(m_last), 64'd0);
        chk("mid_beat0", 64'(beat_cnt), 64'd0);
        chk("mid_pkt0", 64'(pkt_cnt), 64'd0);
        cycle(1, 1, 0);
        chk("mid_next_data", 64'(m_data), 64'd7);
        repeat (29) cycle(1, 1, 0);
        chk("mid_beats_after", 64'(beat_cnt), 64'd29);
        chk("mid_pkts_after", 64'(pkt_cnt), 64'd1);

        // empty FIFO, then a single word
        fifo.delete();
        cycle(0, 0, 1);
        repeat (20) cycle(1, 1, 0);
        chk("empty_beats", 64'(beat_cnt), 64'd0);
        fifo.push_back(12'h5A5);
        repeat (5) cycle(1, 1, 0);
        chk("single_beats", 64'(beat_cnt), 64'd1);
        chk("single_word", 64'(last_word), 64'h5A5);
        chk("single_drained", 64'(m_valid), 64'd0);

        // randomized traffic
        fifo.delete();
        cycle(0, 0, 1);
        repeat (600) begin
            if ($urandom_range(0, 2) != 0) fifo.push_back(12'($urandom));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
        end

        // saturation: PKT_LEN=1, 4-bit counters
        @(negedge clock);
        s_sclr = 0;
        repeat (11) @(negedge clock);
        chk("sat_beat_mid", 64'(s_beat), 64'd10);
        chk("sat_pkt_mid", 64'(s_pkt), 64'd10);
        chk("sat_last", 64'(s_last), 64'd1);
        repeat (20) @(negedge clock);
        chk("sat_beat", 64'(s_beat), 64'd15);
        chk("sat_pkt", 64'(s_pkt), 64'd15);
        chk("sat_valid", 64'(s_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
